// File: rtl/xil_bram_sdp_1clk_clr_if.sv
// User-side bus of the single-clock SDP BRAM with clear engine.
// The master drives the strobes; the slave returns read data, read valid and ready.
interface xil_bram_sdp_1clk_clr_if #(
    parameter int ADR = 8,
    parameter int DAT = 16,
    parameter int NBE = 2
);
    logic           clr;
    logic           wen;
    logic [NBE-1:0] wbe;
    logic [ADR-1:0] wad;
    logic [DAT-1:0] wda;
    logic           ren;
    logic [ADR-1:0] rad;
    logic [DAT-1:0] rda;
    logic           rvl;
    logic           rdy;

    modport master (output clr, wen, wbe, wad, wda, ren, rad, input rda, rvl, rdy);
    modport slave  (input clr, wen, wbe, wad, wda, ren, rad, output rda, rvl, rdy);
endinterface

// File: rtl/xil_bram_sdp_1clk_clr.sv
// Single-clock simple-dual-port BRAM with lane write enables, optional write bypass,
// 1- or 2-stage read pipeline and a zeroing sweep after reset or on clear.
module xil_bram_sdp_1clk_clr #(
    parameter int ADR = 8,
    parameter int DAT = 16,
    parameter int DEP = 256,
    parameter int NBE = 2,
    parameter int DEL = 1,
    parameter int BYP = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    xil_bram_sdp_1clk_clr_if.slave bus
);
    localparam int             LW    = DAT / NBE;
    localparam logic [ADR:0]   DEP_W = (ADR + 1)'(DEP);
    localparam logic [ADR-1:0] LAST  = ADR'(DEP - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t         r_state;
    logic [ADR-1:0] r_cnt;
    logic           r_rdy;
    logic [DAT-1:0] r_mem [DEP];
    logic           r_s1_vld;
    logic [DAT-1:0] r_s1_dat;

    logic           w_act;
    logic           w_wad_ok;
    logic           w_rad_ok;
    logic           w_wr_acc;
    logic           w_rd_acc;
    logic           w_mem_we;
    logic [ADR-1:0] w_mem_adr;
    logic [DAT-1:0] w_mem_dat;
    logic [NBE-1:0] w_mem_be;
    logic [DAT-1:0] w_rd_dat;

    // A clear request in RUN wins over user strobes in the same cycle.
    assign w_act    = r_rdy & ~bus.clr;
    assign w_wad_ok = {1'b0, bus.wad} < DEP_W;
    assign w_rad_ok = {1'b0, bus.rad} < DEP_W;
    assign w_wr_acc = w_act & bus.wen & w_wad_ok;
    assign w_rd_acc = w_act & bus.ren;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (bus.clr) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= RUN;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.clr) begin
                        r_state <= INIT;
                        r_cnt   <= '0;
                        r_rdy   <= 1'b0;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    // The sweep owns the single write port while INIT.
    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_adr = bus.wad;
        w_mem_dat = bus.wda;
        w_mem_be  = bus.wbe;
        if (r_state == INIT) begin
            w_mem_we  = rstn;
            w_mem_adr = r_cnt;
            w_mem_dat = '0;
            w_mem_be  = '1;
        end else if (w_wr_acc) begin
            w_mem_we  = rstn;
        end
    end

    // NOTE: the array has no reset branch so it maps onto block RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NBE; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_adr][i*LW +: LW] <= w_mem_dat[i*LW +: LW];
                end
            end
        end
    end

    always_comb begin
        w_rd_dat = '0;
        if (w_rad_ok) begin
            w_rd_dat = r_mem[bus.rad];
            if (BYP != 0 && bus.wen && bus.rad == bus.wad) begin
                for (int i = 0; i < NBE; i++) begin
                    if (bus.wbe[i]) begin
                        w_rd_dat[i*LW +: LW] = bus.wda[i*LW +: LW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_dat <= w_rd_dat;
            end
        end
    end

    // The output stage keeps draining during INIT so in-flight reads complete.
    if (DEL == 2) begin : g_del2
        logic           r_s2_vld;
        logic [DAT-1:0] r_s2_dat;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_s2_vld <= 1'b0;
                r_s2_dat <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_dat <= r_s1_dat;
                end
            end
        end

        assign bus.rda = r_s2_dat;
        assign bus.rvl = r_s2_vld;
    end else begin : g_del1
        assign bus.rda = r_s1_dat;
        assign bus.rvl = r_s1_vld;
    end

    assign bus.rdy = r_rdy;
endmodule
